// File: rtl/key_press_encoder_if.sv
// Key-input bus between the raw push buttons and the lock statemachine.
// master drives the raw active-low buttons; slave is the encoder that returns debounced key events.
interface key_press_encoder_if #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) ();
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_pulse;
  logic                key_valid;
  logic [IDX_W-1:0]    key_index;

  modport master (output key_n, input key_held, key_pulse, key_valid, key_index);
  modport slave  (input key_n, output key_held, key_pulse, key_valid, key_index);
endinterface

// File: rtl/key_press_encoder.sv
// Synchronises and debounces active-low push buttons into one-cycle press events with a key index.
// Optional auto-repeat while a key stays held is compiled in with `define KEY_AUTOREPEAT_EN.
module key_press_encoder #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
`ifdef KEY_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
`endif
  parameter int IDX_W           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input logic               clock,
  input logic               reset,
  key_press_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] s;

  key_state_e          state_q [NUM_KEYS];
  key_state_e          state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] press;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    index_q, index_d;

  always_comb begin
    sync1_d = bus.key_n;
    sync2_d = sync1_q;
    s       = ~sync2_q;
  end

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    held_d = '0;
    press  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (s[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      endcase
      held_d[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
      // A press event is the first registered cycle of PRESSED seen while the held output is still low.
      press[i]  = (state_q[i] == PRESSED) && !held_q[i];
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0]    rpt_q [NUM_KEYS];
  logic [RPT_W-1:0]    rpt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] phase_q, phase_d;
  logic [NUM_KEYS-1:0] rep_q, rep_d;

  // phase_q selects the first (REPEAT_DELAY) or later (REPEAT_PERIOD) interval; rep_q marks a repeat pulse.
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rpt_d[i]   = rpt_q[i];
      phase_d[i] = phase_q[i];
      if (!held_q[i]) begin
        rpt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (pulse_q[i]) begin
        rpt_d[i]   = RPT_W'(1);
        phase_d[i] = rep_q[i];
      end else if (rpt_q[i] == (phase_q[i] ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
        rep_d[i] = held_d[i];
      end else begin
        rpt_d[i] = rpt_q[i] + 1'b1;
      end
    end
    pulse_d = press | rep_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        rpt_q[i] <= '0;
      end
      phase_q <= '0;
      rep_q   <= '0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
    end
  end
`else
  always_comb begin
    pulse_d = press;
  end
`endif

  always_comb begin
    valid_d = |pulse_d;
    index_d = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pulse_d[i]) begin
        index_d = IDX_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      // NOTE: the per-key state and counter arrays are plain flops, so they are reset like any register.
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      held_q  <= '0;
      pulse_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  assign bus.key_held  = held_q;
  assign bus.key_pulse = pulse_q;
  assign bus.key_valid = valid_q;
  assign bus.key_index = index_q;

endmodule

// File: tb/tb_key_press_encoder.sv
// Bench for key_press_encoder: directed scenarios plus random button activity, checked by a
// run-length debounce model whose expected pulse events are queued and matched by a monitor.
module tb_key_press_encoder;

  localparam int NK  = 4;
  localparam int DEB = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD  = 10;
  localparam int RP  = 3;
`endif

  logic clock;
  logic reset;

  key_press_encoder_if #(.NUM_KEYS(NK), .IDX_W(2)) bus ();

  key_press_encoder #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
`ifdef KEY_AUTOREPEAT_EN
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
`endif
    .IDX_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [1:0] idx;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest = 2'(i);
    end
  endfunction

  // Reference model: a level flips once DEB consecutive synchronised samples disagree with it.
  logic [3:0] p1 = '0, p2 = '0, lvl = '0, rose = '0, exp_held = '0;
  int         run [NK];
  int         t   [NK];

  always @(posedge clock) begin
    logic [3:0] x;
    logic [3:0] exp_pulse;
    cyc++;
    if (reset) begin
      p1 = '0; p2 = '0; lvl = '0; rose = '0; exp_held = '0;
      for (int i = 0; i < NK; i++) begin
        run[i] = 0;
        t[i]   = 0;
      end
    end else begin
      exp_held  = lvl;
      exp_pulse = '0;
      for (int i = 0; i < NK; i++) begin
        if (lvl[i] && rose[i]) begin
          exp_pulse[i] = 1'b1;
          t[i] = 0;
        end else if (lvl[i]) begin
          t[i]++;
`ifdef KEY_AUTOREPEAT_EN
          if (t[i] >= RD && (t[i] - RD) % RP == 0) exp_pulse[i] = 1'b1;
`endif
        end
      end
      if (exp_pulse != 0) exp_q.push_back('{cyc: cyc, pulse: exp_pulse, idx: lowest(exp_pulse)});
      x  = p2;
      p2 = p1;
      p1 = ~bus.key_n;
      rose = '0;
      for (int i = 0; i < NK; i++) begin
        if (x[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            lvl[i]  = x[i];
            run[i]  = 0;
            rose[i] = x[i];
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  // Monitor: compares held level every cycle and matches presented pulses to queued events.
  int pulse_cnt [NK];
  int key0_cycles[$];
  logic [1:0] last_idx = '0;

  initial begin
    for (int i = 0; i < NK; i++) pulse_cnt[i] = 0;
    forever begin
      @(posedge clock);
      #2;
      check("key_held", bus.key_held == exp_held, 32'(bus.key_held), 32'(exp_held));
      if (bus.key_valid || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
        ev_t e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{cyc: -1, pulse: 4'b0000, idx: 2'b00};
        check("pulse_cycle", e.cyc == cyc, 32'(cyc), 32'(e.cyc));
        check("key_pulse", bus.key_pulse == e.pulse, 32'(bus.key_pulse), 32'(e.pulse));
        check("key_valid", bus.key_valid == (e.pulse != 0), 32'(bus.key_valid), 32'(e.pulse != 0));
        check("key_index", bus.key_index == e.idx, 32'(bus.key_index), 32'(e.idx));
        for (int i = 0; i < NK; i++) if (bus.key_pulse[i]) pulse_cnt[i]++;
        if (bus.key_pulse[0]) key0_cycles.push_back(cyc);
        last_idx = bus.key_index;
      end else begin
        check("idle_outputs", bus.key_pulse == 0 && bus.key_index == 0,
              32'({bus.key_pulse, bus.key_index}), 32'(0));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_outs(input string name, input logic [3:0] held, input logic [3:0] pulse,
                            input logic valid, input logic [1:0] idx);
    check({name, "_held"},  bus.key_held == held,   32'(bus.key_held),  32'(held));
    check({name, "_pulse"}, bus.key_pulse == pulse, 32'(bus.key_pulse), 32'(pulse));
    check({name, "_valid"}, bus.key_valid == valid, 32'(bus.key_valid), 32'(valid));
    check({name, "_index"}, bus.key_index == idx,   32'(bus.key_index), 32'(idx));
  endtask

  initial begin
    int snap [NK];
    reset     = 1'b1;
    bus.key_n = '1;
    cycles(3);
    reset = 1'b0;
    edges(1);
    check_outs("reset_state", 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Test 1: key 2 pressed for 12 sampled cycles.
    @(negedge clock);
    bus.key_n = 4'b1011;
    edges(6);
    check_outs("t1_before", 4'b0000, 4'b0000, 1'b0, 2'd0);
    edges(1);
    check_outs("t1_pulse", 4'b0100, 4'b0100, 1'b1, 2'd2);
    edges(1);
    check_outs("t1_after", 4'b0100, 4'b0000, 1'b0, 2'd0);
    cycles(5);
    // Test 4: release key 2; the held level falls after the same latency with no pulse.
    bus.key_n = 4'b1111;
    edges(6);
    check("t4_still_held", bus.key_held == 4'b0100, 32'(bus.key_held), 32'h4);
    edges(1);
    check("t4_fall", bus.key_held == 4'b0000, 32'(bus.key_held), 32'h0);
`ifdef KEY_AUTOREPEAT_EN
    // The first repeat lands 10 cycles after the press, before the release has debounced.
    check("t1_pulse_count", pulse_cnt[2] == 2, 32'(pulse_cnt[2]), 32'd2);
`else
    check("t1_pulse_count", pulse_cnt[2] == 1, 32'(pulse_cnt[2]), 32'd1);
`endif
    cycles(8);

    // Test 2: a bounce shorter than the window, then a long press.
    @(negedge clock);
    bus.key_n = 4'b1110;
    cycles(3);
    bus.key_n = 4'b1111;
    cycles(1);
    bus.key_n = 4'b1110;
    cycles(3);
    check("t2_no_pulse", pulse_cnt[0] == 0, 32'(pulse_cnt[0]), 32'd0);
    check("t2_not_held", bus.key_held[0] == 1'b0, 32'(bus.key_held[0]), 32'd0);
    cycles(6);
    bus.key_n = 4'b1111;
    cycles(12);
    check("t2_one_pulse", pulse_cnt[0] == 1, 32'(pulse_cnt[0]), 32'd1);
    check("t2_index", last_idx == 2'd0, 32'(last_idx), 32'd0);

    // Test 3: keys 1 and 3 pressed together.
    for (int i = 0; i < NK; i++) snap[i] = pulse_cnt[i];
    @(negedge clock);
    bus.key_n = 4'b0101;
    edges(6);
    check_outs("t3_before", 4'b0000, 4'b0000, 1'b0, 2'd0);
    edges(1);
    check_outs("t3_pulse", 4'b1010, 4'b1010, 1'b1, 2'd1);
    cycles(2);
    bus.key_n = 4'b1111;
    cycles(12);
    check("t3_count_k1", pulse_cnt[1] - snap[1] == 1, 32'(pulse_cnt[1] - snap[1]), 32'd1);
    check("t3_count_k3", pulse_cnt[3] - snap[3] == 1, 32'(pulse_cnt[3] - snap[3]), 32'd1);
    check("t3_count_k0", pulse_cnt[0] - snap[0] == 0, 32'(pulse_cnt[0] - snap[0]), 32'd0);

    // Test 5: reset while key 1 is mid-debounce; a full window is needed afterwards.
    @(negedge clock);
    bus.key_n = 4'b1101;
    edges(4);
    @(negedge clock);
    reset = 1'b1;
    edges(1);
    check_outs("t5_in_reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
    @(negedge clock);
    reset = 1'b0;
    edges(6);
    check_outs("t5_before", 4'b0000, 4'b0000, 1'b0, 2'd0);
    edges(1);
    check_outs("t5_pulse", 4'b0010, 4'b0010, 1'b1, 2'd1);
    cycles(1);
    bus.key_n = 4'b1111;
    cycles(12);

    // Test 6: key 0 held for 20 cycles beyond its press pulse.
    key0_cycles.delete();
    @(negedge clock);
    bus.key_n = 4'b1110;
    cycles(20);
    bus.key_n = 4'b1111;
    cycles(12);
`ifdef KEY_AUTOREPEAT_EN
    check("t6_pulse_count", key0_cycles.size() == 5, 32'(key0_cycles.size()), 32'd5);
    if (key0_cycles.size() == 5) begin
      check("t6_rep1", key0_cycles[1] - key0_cycles[0] == 10, 32'(key0_cycles[1] - key0_cycles[0]), 32'd10);
      check("t6_rep2", key0_cycles[2] - key0_cycles[0] == 13, 32'(key0_cycles[2] - key0_cycles[0]), 32'd13);
      check("t6_rep3", key0_cycles[3] - key0_cycles[0] == 16, 32'(key0_cycles[3] - key0_cycles[0]), 32'd16);
      check("t6_rep4", key0_cycles[4] - key0_cycles[0] == 19, 32'(key0_cycles[4] - key0_cycles[0]), 32'd19);
    end
`else
    check("t6_pulse_count", key0_cycles.size() == 1, 32'(key0_cycles.size()), 32'd1);
`endif

    // Random button activity, including bounces shorter than the debounce window.
    for (int n = 0; n < 80; n++) begin
      bus.key_n = 4'($urandom_range(0, 15));
      cycles($urandom_range(1, 12));
    end
    bus.key_n = 4'b1111;
    cycles(20);
    check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
